divider_ex: RTL and testbench

Multi-cycle unsigned integer divider for the MiniCore execute stage. It computes quotient and remainder of two WIDTH-bit operands by restoring shift-subtract, one quotient bit per clock. A start/busy/done handshake lets the control unit stall the pipeline while it runs. It is the inverse-arithmetic companion to the single-cycle adder/multiplier path.

---
 rtl/divider_ex.sv | 135 +++++++++++++
 tb/tb_divider_ex.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_ex.sv
// Multi-cycle unsigned divider: restoring shift-subtract, one quotient bit per clock.
// Divide-by-zero finishes in one cycle with Q = all ones, R = A and div_zero set.
module divider_ex #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] qo_q, qo_d;
    logic [WIDTH-1:0] ro_q, ro_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;

    // Next-state, datapath iteration and output-register loads
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        qo_d    = qo_q;
        ro_d    = ro_q;
        dz_d    = dz_q;
        trial   = {rem_q, q_q[WIDTH-1]};
        // The true difference is below the divisor, so WIDTH bits hold it exactly.
        diff    = trial[WIDTH-1:0] - div_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (B == {WIDTH{1'b0}}) begin
                        qo_d    = {WIDTH{1'b1}};
                        ro_d    = A;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        q_d     = A;
                        div_d   = B;
                        rem_d   = {WIDTH{1'b0}};
                        cnt_d   = CW'(WIDTH);
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (trial >= {1'b0, div_q}) begin
                    rem_d = diff;
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    qo_d    = q_d;
                    ro_d    = rem_d;
                    dz_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            div_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            qo_q    <= {WIDTH{1'b0}};
            ro_q    <= {WIDTH{1'b0}};
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            qo_q    <= qo_d;
            ro_q    <= ro_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign Q        = qo_q;
    assign R        = ro_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_divider_ex.sv
// Bench for divider_ex: cycle-level behavioural model compared every cycle,
// plus literal expectations for directed cases and a random invariant sweep.
module tb_divider_ex;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         div_zero;

    divider_ex #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Q        (Q),
        .R        (R),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: counts cycles and uses plain / and % for the result.
    logic         m_busy, m_done, m_dz;
    logic [W-1:0] m_q, m_r, m_pq, m_pr;
    int           m_cnt;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_q <= '0; m_r <= '0; m_cnt <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                if (B == 0) begin
                    m_done <= 1'b1; m_q <= '1; m_r <= A; m_dz <= 1'b1;
                end else begin
                    m_cnt <= W; m_pq <= A / B; m_pr <= A % B;
                end
            end
        end else if (m_done) begin
            m_done <= 1'b0; m_busy <= 1'b0;
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1; m_q <= m_pq; m_r <= m_pr; m_dz <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("Q", 64'(Q), 64'(m_q));
            chk("R", 64'(R), 64'(m_r));
            chk("div_zero", 64'(div_zero), 64'(m_dz));
        end
    end

    // Issue one start from IDLE, scramble operands after acceptance, wait for done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke,
                         output int lat);
        @(negedge clk);
        start = 1'b1; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        lat = 1;
        while (!done && lat < W + 8) begin
            if (poke && lat == 5) begin
                start = 1'b1; A = $urandom; B = $urandom_range(1, 50);
            end
            if (poke && lat == 6) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < W + 8);
        chk("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        int lat;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; start = 1'b1; A = $urandom; B = $urandom;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_Q", 64'(Q), 64'd0);
        chk("rst_R", 64'(R), 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        rst_n = 1'b1; start = 1'b0;

        do_op(32'd100, 32'd7, 1'b0, lat);
        chk("lat_100_7", 64'(lat), 64'd33);
        chk("Q_100_7", 64'(Q), 64'd14);
        chk("R_100_7", 64'(R), 64'd2);
        chk("dz_100_7", 64'(div_zero), 64'd0);

        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
        chk("Q_max_1", 64'(Q), 64'hFFFF_FFFF);
        chk("R_max_1", 64'(R), 64'd0);

        do_op(32'd5, 32'd9, 1'b0, lat);
        chk("Q_5_9", 64'(Q), 64'd0);
        chk("R_5_9", 64'(R), 64'd5);

        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
        chk("Q_msb_max", 64'(Q), 64'd0);
        chk("R_msb_max", 64'(R), 64'h8000_0000);

        do_op(32'h1234, 32'd0, 1'b0, lat);
        chk("lat_div0", 64'(lat), 64'd1);
        chk("busy_div0", 64'(busy), 64'd1);
        chk("Q_div0", 64'(Q), 64'hFFFF_FFFF);
        chk("R_div0", 64'(R), 64'h1234);
        chk("dz_div0", 64'(div_zero), 64'd1);

        do_op(32'd100, 32'd7, 1'b1, lat);
        chk("dz_cleared", 64'(div_zero), 64'd0);
        chk("Q_poke", 64'(Q), 64'd14);
        chk("R_poke", 64'(R), 64'd2);
        chk("lat_poke", 64'(lat), 64'd33);

        // Start held high: second operation accepted on the first IDLE edge after DONE.
        @(negedge clk);
        start = 1'b1; A = 32'd20; B = 32'd3;
        wait_done(lat);
        chk("Q_hold1", 64'(Q), 64'd6);
        chk("R_hold1", 64'(R), 64'd2);
        A = 32'd50; B = 32'd6;
        wait_done(lat);
        chk("lat_hold2", 64'(lat), 64'd34);
        chk("Q_hold2", 64'(Q), 64'd8);
        chk("R_hold2", 64'(R), 64'd2);
        start = 1'b0;
        @(negedge clk);

        // Reset mid-RUN abandons the operation.
        @(negedge clk);
        start = 1'b1; A = 32'd1000; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_Q", 64'(Q), 64'd0);
        chk("mid_R", 64'(R), 64'd0);
        rst_n = 1'b1;
        do_op(32'd1000, 32'd3, 1'b0, lat);
        chk("Q_after_rst", 64'(Q), 64'd333);
        chk("R_after_rst", 64'(R), 64'd1);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            case (i % 3)
                0: rb = $urandom_range(1, 255);
                1: rb = $urandom_range(1, 32'hFFFF);
                default: rb = ($urandom == 0) ? 32'd1 : $urandom;
            endcase
            do_op(ra, rb, 1'b0, lat);
            chk("invariant", 64'(Q) * 64'(rb) + 64'(R), 64'(ra));
            chk("r_lt_b", 64'(R < rb), 64'd1);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
